vocab_token_matcher: RTL and testbench
======================================

// Module: vocab_token_matcher
// PURPOSE
// Multi-word vocabulary matcher with exact and greedy longest-prefix modes, built for the tokenizer path.
// Walks a vocabulary memory holding NUL-terminated words and compares each word against a NUL-terminated
// input string. Reports whether a match exists, the index of the matching word, its start address and its length.
// Sits between the vocab/input RAM read ports and the tokenizer control FSM; one token lookup per start pulse.
// PARAMETERS
// ADDR_WIDTH  4  address width of both memories; all address arithmetic wraps mod 2**ADDR_WIDTH
// DATA_WIDTH  8  character width; value 0 is the word/string terminator (NUL)
// TOK_WIDTH   4  width of token_id; the word counter wraps mod 2**TOK_WIDTH
// PORTS
// clk               in   1           single clock, rising edge
// rst               in   1           synchronous, active-high reset
// start             in   1           begin a lookup; honoured only while busy=0
// mode              in   1           0 = exact match, 1 = longest-prefix match; sampled on start
// vocab_start_addr  in   ADDR_WIDTH  first vocab address; sampled on start
// vocab_end_addr    in   ADDR_WIDTH  exclusive end of vocab region; sampled on start
// input_start_addr  in   ADDR_WIDTH  first input character address; sampled on start
// val_vocab         in   DATA_WIDTH  vocab RAM data at addr_v; combinational read, same cycle
// val_input         in   DATA_WIDTH  input RAM data at addr_i; combinational read, same cycle
// addr_v            out  ADDR_WIDTH  vocab read address (registered)
// addr_i            out  ADDR_WIDTH  input read address (registered)
// busy              out  1           high from the cycle after start until done
// done              out  1           single-cycle pulse when the result is valid
// found             out  1           a match was found; held until the next start
// token_id          out  TOK_WIDTH   index of the matched word (0 = first word); held
// match_addr        out  ADDR_WIDTH  start address of the matched word; held
// match_len         out  ADDR_WIDTH  number of non-NUL characters matched; held
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE. Asserting rst mid-lookup aborts it. No done pulse is produced.
// - States: IDLE, CMP, SKIP.
// - IDLE + start: latch configuration; av<=vocab_start, ai<=input_start; word_start<=vocab_start;
//   tok<=0; len<=0; best cleared; found, token_id, match_addr and match_len cleared; go to CMP.
// - CMP / SKIP are evaluated each cycle, in priority order. End check: if av==vocab_end_addr, finish.
//   A trailing word with no terminating NUL before the end never matches.
// - CMP, val_vocab!=0 and val_vocab==val_input: av++, ai++, len++.
// - CMP, val_vocab!=0, and (mismatch or val_input==0): go to SKIP.
// - CMP, val_vocab==0 (end of word):
//   - exact mode: if val_input==0 and len>0, finish found (this word).
//   - prefix mode: if len>0 and len>best_len, record best (tok, word_start, len). Equal length keeps the earlier word.
//   - in every non-finishing case, advance to the next word: av<=av+1; word_start<=av+1; tok++; ai<=input_start; len<=0.
//   - Empty words (consecutive NULs) consume one index and never match.
// - SKIP: av++ each cycle until val_vocab==0, then advance to the next word (as above) and return to CMP.
// - Finish:
//   - exact mode: found=1, token_id=tok, match_addr=word_start, match_len=len.
//   - prefix mode: found=best_valid, and the outputs take the best record (zeros if none).
//   - Outputs are registered together with done=1 and busy=0; return to IDLE.
// - Exact mode: the first matching word wins.
// - Throughput: one character compare per cycle. Cycle count is data dependent.
// - Empty vocab (start==end): done rises at the 1st edge after the start edge, with found=0.
// - start while busy is ignored. Configuration inputs may change freely after the start edge.
// - An unterminated input string wraps ai modulo the depth; callers must NUL-terminate.
// TESTING
// Vocab image: mem[0..8] = 'a','b',0,'a','b','c',0,'b',0; vocab_start=0, vocab_end=9, input_start=0.
// 1. Exact mode, input "abc\0" -> done at the 7th edge after the start edge; found=1, token_id=1, match_addr=3, match_len=3.
// 2. Prefix mode, input "abd\0" -> found=1, token_id=0, match_addr=0, match_len=2 (word "abc" fails on 'd').
// 3. Exact mode, input "x\0" -> found=0, token_id=0, match_addr=0, match_len=0; busy low after done.
// 4. Empty vocab (start=end=5) -> done one edge after the start edge, found=0.
//    A second start pulse while busy is ignored: exactly one done pulse.
// 5. Assert rst for 1 cycle mid-lookup -> busy=0, done=0, outputs 0.
//    Then a fresh start with case 1 reproduces the case 1 result exactly.
// 6. Prefix mode, tie: vocab "ab\0ab\0", end=6, input "ab\0" -> token_id=0, match_len=2.

Source files
------------

// File: rtl/vocab_token_matcher.sv
// Vocabulary matcher: walks NUL-terminated words and compares them against a NUL-terminated input string.
// Exact mode returns the first equal word; prefix mode returns the longest word that prefixes the input.
module vocab_token_matcher #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8,
  parameter int TOK_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] vocab_start_addr,
  input  logic [ADDR_WIDTH-1:0] vocab_end_addr,
  input  logic [ADDR_WIDTH-1:0] input_start_addr,
  input  logic [DATA_WIDTH-1:0] val_vocab,
  input  logic [DATA_WIDTH-1:0] val_input,
  output logic [ADDR_WIDTH-1:0] addr_v,
  output logic [ADDR_WIDTH-1:0] addr_i,
  output logic                  busy,
  output logic                  done,
  output logic                  found,
  output logic [TOK_WIDTH-1:0]  token_id,
  output logic [ADDR_WIDTH-1:0] match_addr,
  output logic [ADDR_WIDTH-1:0] match_len
);

  typedef enum logic [1:0] {IDLE, CMP, SKIP} state_t;

  state_t                state_q, state_d;
  logic                  cfg_mode;
  logic [ADDR_WIDTH-1:0] cfg_vend, cfg_istart;
  logic [ADDR_WIDTH-1:0] word_start, len;
  logic [TOK_WIDTH-1:0]  tok;
  logic                  best_valid;
  logic [TOK_WIDTH-1:0]  best_tok;
  logic [ADDR_WIDTH-1:0] best_addr, best_len;

  logic fin, exact_hit, step, skip_inc, adv, rec;
  logic at_end, vnul, inul;

  assign at_end = (addr_v == cfg_vend);
  assign vnul   = (val_vocab == '0);
  assign inul   = (val_input == '0);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    fin       = 1'b0;
    exact_hit = 1'b0;
    step      = 1'b0;
    skip_inc  = 1'b0;
    adv       = 1'b0;
    rec       = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = CMP;
      CMP: begin
        if (at_end) begin
          fin = 1'b1;
        end else if (!vnul) begin
          // Equal non-NUL vocab char implies input char is non-NUL too
          if (val_vocab == val_input) step = 1'b1;
          else                        state_d = SKIP;
        end else if (!cfg_mode && inul && len != '0) begin
          fin       = 1'b1;
          exact_hit = 1'b1;
        end else begin
          adv = 1'b1;
          rec = cfg_mode && len != '0 && len > best_len;
        end
      end
      SKIP: begin
        if (at_end) begin
          fin = 1'b1;
        end else if (vnul) begin
          adv     = 1'b1;
          state_d = CMP;
        end else begin
          skip_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (fin) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_mode <= 1'b0; cfg_vend <= '0; cfg_istart <= '0;
      addr_v <= '0; addr_i <= '0; word_start <= '0; len <= '0; tok <= '0;
      best_valid <= 1'b0; best_tok <= '0; best_addr <= '0; best_len <= '0;
      busy <= 1'b0; done <= 1'b0; found <= 1'b0;
      token_id <= '0; match_addr <= '0; match_len <= '0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE && start) begin
        cfg_mode   <= mode;
        cfg_vend   <= vocab_end_addr;
        cfg_istart <= input_start_addr;
        addr_v     <= vocab_start_addr;
        addr_i     <= input_start_addr;
        word_start <= vocab_start_addr;
        tok        <= '0;
        len        <= '0;
        best_valid <= 1'b0; best_tok <= '0; best_addr <= '0; best_len <= '0;
        found      <= 1'b0; token_id <= '0; match_addr <= '0; match_len <= '0;
        busy       <= 1'b1;
      end
      if (step) begin
        addr_v <= addr_v + 1'b1;
        addr_i <= addr_i + 1'b1;
        len    <= len + 1'b1;
      end
      if (skip_inc) addr_v <= addr_v + 1'b1;
      if (adv) begin
        addr_v     <= addr_v + 1'b1;
        word_start <= addr_v + 1'b1;
        tok        <= tok + 1'b1;
        addr_i     <= cfg_istart;
        len        <= '0;
      end
      if (rec) begin
        best_valid <= 1'b1;
        best_tok   <= tok;
        best_addr  <= word_start;
        best_len   <= len;
      end
      if (fin) begin
        done <= 1'b1;
        busy <= 1'b0;
        if (exact_hit) begin
          found <= 1'b1; token_id <= tok; match_addr <= word_start; match_len <= len;
        end else if (cfg_mode) begin
          found <= best_valid; token_id <= best_tok; match_addr <= best_addr; match_len <= best_len;
        end
      end
    end
  end

endmodule

// File: tb/tb_vocab_token_matcher.sv
// Directed bench for vocab_token_matcher: exact, prefix, tie, empty vocab, reset abort, start-while-busy.
module tb_vocab_token_matcher;

  logic       clk = 1'b0;
  logic       rst, start, mode;
  logic [3:0] vocab_start_addr, vocab_end_addr, input_start_addr;
  logic [7:0] val_vocab, val_input;
  logic [3:0] addr_v, addr_i;
  logic       busy, done, found;
  logic [3:0] token_id, match_addr, match_len;

  logic [7:0] vmem [16];
  logic [7:0] imem [16];
  int n_cmp = 0;
  int n_bad = 0;

  assign val_vocab = vmem[addr_v];
  assign val_input = imem[addr_i];

  always #5 clk = ~clk;

  vocab_token_matcher #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .TOK_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .vocab_start_addr(vocab_start_addr), .vocab_end_addr(vocab_end_addr),
    .input_start_addr(input_start_addr), .val_vocab(val_vocab), .val_input(val_input),
    .addr_v(addr_v), .addr_i(addr_i), .busy(busy), .done(done), .found(found),
    .token_id(token_id), .match_addr(match_addr), .match_len(match_len)
  );

  task automatic load_vocab_default();
    for (int i = 0; i < 16; i++) vmem[i] = 8'h00;
    vmem[0] = "a"; vmem[1] = "b"; vmem[3] = "a"; vmem[4] = "b"; vmem[5] = "c"; vmem[7] = "b";
  endtask

  task automatic load_input(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2, input logic [7:0] c3);
    for (int i = 0; i < 16; i++) imem[i] = 8'h00;
    imem[0] = c0; imem[1] = c1; imem[2] = c2; imem[3] = c3;
  endtask

  // Pulse start for one edge; returns at the start edge + 1 time unit.
  task automatic do_start(input logic m, input logic [3:0] vs, input logic [3:0] ve, input logic [3:0] is);
    start = 1'b1; mode = m; vocab_start_addr = vs; vocab_end_addr = ve; input_start_addr = is;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk); #1;
      edges++;
    end while (!done && edges < 100);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode = 1'b0;
    vocab_start_addr = '0; vocab_end_addr = '0; input_start_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy, done, found, token_id, match_addr, match_len, addr_v, addr_i} !== 23'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h, want 0",
               {busy, done, found, token_id, match_addr, match_len, addr_v, addr_i});
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_exact_match();
    int e;
    load_vocab_default(); load_input("a", "b", "c", 8'h00);
    do_start(1'b0, 4'd0, 4'd9, 4'd0);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL exact_busy_after_start: got %b, want 1", busy); end
    wait_done(e);
    n_cmp++;
    if (e != 7) begin n_bad++; $display("FAIL exact_latency: got %0d edges, want 7", e); end
    n_cmp++;
    if ({done, busy, found, token_id, match_addr, match_len} !== {1'b1, 1'b0, 1'b1, 4'd1, 4'd3, 4'd3}) begin
      n_bad++;
      $display("FAIL exact_result: got d%b b%b f%b tok%0d addr%0d len%0d, want d1 b0 f1 tok1 addr3 len3",
               done, busy, found, token_id, match_addr, match_len);
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({done, found, token_id, match_len} !== {1'b0, 1'b1, 4'd1, 4'd3}) begin
      n_bad++;
      $display("FAIL exact_hold: got d%b f%b tok%0d len%0d, want d0 f1 tok1 len3", done, found, token_id, match_len);
    end
  endtask

  task automatic test_prefix_match();
    int e;
    load_vocab_default(); load_input("a", "b", "d", 8'h00);
    do_start(1'b1, 4'd0, 4'd9, 4'd0);
    wait_done(e);
    n_cmp++;
    if ({done, found, token_id, match_addr, match_len} !== {1'b1, 1'b1, 4'd0, 4'd0, 4'd2}) begin
      n_bad++;
      $display("FAIL prefix_result: got d%b f%b tok%0d addr%0d len%0d, want d1 f1 tok0 addr0 len2",
               done, found, token_id, match_addr, match_len);
    end
  endtask

  task automatic test_no_match();
    int e;
    load_vocab_default(); load_input("x", 8'h00, 8'h00, 8'h00);
    do_start(1'b0, 4'd0, 4'd9, 4'd0);
    wait_done(e);
    n_cmp++;
    if ({done, busy, found, token_id, match_addr, match_len} !== {1'b1, 1'b0, 1'b0, 12'd0}) begin
      n_bad++;
      $display("FAIL nomatch_result: got d%b b%b f%b tok%0d addr%0d len%0d, want d1 b0 f0 tok0 addr0 len0",
               done, busy, found, token_id, match_addr, match_len);
    end
  endtask

  task automatic test_empty_vocab();
    int pulses;
    // Hold start across the busy cycle; the second edge must be ignored.
    start = 1'b1; mode = 1'b0; vocab_start_addr = 4'd5; vocab_end_addr = 4'd5; input_start_addr = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if ({done, busy, found} !== 3'b100) begin
      n_bad++;
      $display("FAIL empty_done: got d%b b%b f%b, want d1 b0 f0", done, busy, found);
    end
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    n_cmp++;
    if (pulses != 0) begin n_bad++; $display("FAIL empty_single_done: got %0d extra pulses, want 0", pulses); end
  endtask

  task automatic test_mid_reset();
    int bad_cycles;
    int e;
    load_vocab_default(); load_input("a", "b", "c", 8'h00);
    do_start(1'b0, 4'd0, 4'd9, 4'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, found, token_id, match_addr, match_len} !== 15'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: got b%b d%b f%b tok%0d addr%0d len%0d, want all 0",
               busy, done, found, token_id, match_addr, match_len);
    end
    bad_cycles = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) bad_cycles++;
    end
    n_cmp++;
    if (bad_cycles != 0) begin n_bad++; $display("FAIL midreset_quiet: got %0d active cycles, want 0", bad_cycles); end
    do_start(1'b0, 4'd0, 4'd9, 4'd0);
    wait_done(e);
    n_cmp++;
    if (e != 7 || {found, token_id, match_addr, match_len} !== {1'b1, 4'd1, 4'd3, 4'd3}) begin
      n_bad++;
      $display("FAIL midreset_rerun: got edges%0d f%b tok%0d addr%0d len%0d, want edges7 f1 tok1 addr3 len3",
               e, found, token_id, match_addr, match_len);
    end
  endtask

  task automatic test_back_to_back();
    int pulses, done_edge;
    logic [12:0] res;
    load_vocab_default(); load_input("a", "b", "c", 8'h00);
    do_start(1'b0, 4'd0, 4'd9, 4'd0);
    pulses = 0; done_edge = 0; res = '0;
    for (int i = 1; i <= 15; i++) begin
      // A start mid-lookup with different config must be ignored.
      if (i == 2) begin start = 1'b1; mode = 1'b1; vocab_start_addr = 4'd7; end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin pulses++; done_edge = i; res = {found, token_id, match_addr, match_len}; end
    end
    n_cmp++;
    if (pulses != 1 || done_edge != 7) begin
      n_bad++;
      $display("FAIL busy_start_ignored: got %0d pulses at edge %0d, want 1 at edge 7", pulses, done_edge);
    end
    n_cmp++;
    if (res !== {1'b1, 4'd1, 4'd3, 4'd3}) begin
      n_bad++;
      $display("FAIL busy_start_result: got %h, want %h", res, {1'b1, 4'd1, 4'd3, 4'd3});
    end
  endtask

  task automatic test_prefix_tie();
    int e;
    for (int i = 0; i < 16; i++) vmem[i] = 8'h00;
    vmem[0] = "a"; vmem[1] = "b"; vmem[3] = "a"; vmem[4] = "b";
    load_input("a", "b", 8'h00, 8'h00);
    do_start(1'b1, 4'd0, 4'd6, 4'd0);
    wait_done(e);
    n_cmp++;
    if ({done, found, token_id, match_addr, match_len} !== {1'b1, 1'b1, 4'd0, 4'd0, 4'd2}) begin
      n_bad++;
      $display("FAIL prefix_tie: got d%b f%b tok%0d addr%0d len%0d, want d1 f1 tok0 addr0 len2",
               done, found, token_id, match_addr, match_len);
    end
  endtask

  initial begin
    load_vocab_default();
    load_input(8'h00, 8'h00, 8'h00, 8'h00);
    test_reset();
    test_exact_match();
    test_prefix_match();
    test_no_match();
    test_empty_vocab();
    test_mid_reset();
    test_back_to_back();
    test_prefix_tie();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
